banked_regfile: RTL

//  Parametrised multi-bank vector register file for the operand-collector/RAU path.
//  - NUM_BANKS independent banks, each DEPTH entries of LANES x DATA_W.
//  - Per bank: one read-request port, one separate write port with per-lane write mask.
//  - Collector tags (ocid, same) travel with each read and return aligned with data.
//  - Memory is zeroed by a post-reset sweep; init_done gates all traffic.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_bank.sv | 102 ++++++++++
 rtl/banked_regfile.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the banked vector register file.
//   - Default geometry (banks, depth, lanes, lane width, collector id width).
//   - clog2_min1: address width helper that never returns 0.
//   - INIT/RUN state encoding for the top-level sweep FSM.
package rf_pkg;

   localparam int RF_NUM_BANKS = 4;
   localparam int RF_DEPTH     = 8;
   localparam int RF_LANES     = 8;
   localparam int RF_DATA_W    = 32;
   localparam int RF_OCID_W    = 4;

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rf_bank.sv
// rf_bank: one bank of the vector register file.
//   DEPTH entries of LANES x DATA_W, lane-masked write port, registered read
//   port with one cycle of latency. The collector tags (ocid, same) are
//   registered alongside the data so they come back aligned with it.
//   Same-address read/write in one cycle: write-through when RF_WR_BYPASS_EN
//   is defined, read-before-write otherwise.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rd_req/rd_addr/rd_ocid/rd_same   read request and its tags
//   wr_en/wr_addr/wr_mask/wr_data    write port, wr_mask bit l enables lane l
//   rd_valid/rd_data/rd_ocid_q/rd_same_q  registered read response
module rf_bank
   import rf_pkg::*;
#(
   parameter  int DEPTH  = RF_DEPTH,
   parameter  int LANES  = RF_LANES,
   parameter  int DATA_W = RF_DATA_W,
   parameter  int OCID_W = RF_OCID_W,
   localparam int ADDR_W = clog2_min1(DEPTH),
   localparam int EW     = LANES * DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [OCID_W-1:0] rd_ocid,
   input  logic              rd_same,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LANES-1:0]  wr_mask,
   input  logic [EW-1:0]     wr_data,
   output logic              rd_valid,
   output logic [EW-1:0]     rd_data,
   output logic [OCID_W-1:0] rd_ocid_q,
   output logic              rd_same_q
);

   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     wr_merge_d;
   logic [EW-1:0]     rd_entry;

   logic              rd_valid_q, rd_valid_d;
   logic [EW-1:0]     rd_data_q,  rd_data_d;
   logic [OCID_W-1:0] rd_ocid_qq, rd_ocid_d;
   logic              rd_same_qq, rd_same_d;

   // Full entry as it will look after the write: masked lanes from wr_data,
   // the rest from the current contents. Also the bypass source.
   always_comb begin
      wr_merge_d = mem_q[wr_addr];
      for (int l = 0; l < LANES; l++) begin
         if (wr_mask[l]) begin
            wr_merge_d[l*DATA_W +: DATA_W] = wr_data[l*DATA_W +: DATA_W];
         end
      end
   end

   // Storage is deliberately not reset; the top-level sweep zeroes it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_merge_d;
      end
   end

   always_comb begin
      rd_entry = mem_q[rd_addr];
`ifdef RF_WR_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_entry = wr_merge_d;
      end
`endif
      rd_valid_d = rd_req;
      rd_data_d  = rd_data_q;
      rd_ocid_d  = rd_ocid_qq;
      rd_same_d  = rd_same_qq;
      if (rd_req) begin
         rd_data_d = rd_entry;
         rd_ocid_d = rd_ocid;
         rd_same_d = rd_same;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_ocid_qq <= '0;
         rd_same_qq <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_ocid_qq <= rd_ocid_d;
         rd_same_qq <= rd_same_d;
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_ocid_q = rd_ocid_qq;
   assign rd_same_q = rd_same_qq;

endmodule

// File: rtl/banked_regfile.sv
// banked_regfile: NUM_BANKS independent rf_bank instances plus the post-reset
// zero sweep. Traffic is held off until init_done.
// Optional feature: define RF_WR_BYPASS_EN for write-through on a same-cycle
// read/write of the same bank and address (default: read-before-write).
// rst_n asserts asynchronously; its release is expected to be synchronous
// to clk.
// Ports (bank b occupies slice b of each packed vector):
//   clk, rst_n     clock, async active-low reset
//   init_done      high once every entry of every bank has been zeroed
//   rd_req, rd_addr, rd_ocid, rd_same             read requests
//   wr_en, wr_addr, wr_mask, wr_data              lane-masked writes
//   rd_valid, rd_data, rd_ocid_q, rd_same_q       read responses, 1-cycle latency
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | writing zeros to entry cnt of every bank; ports ignored
// ST_RUN  | normal operation, init_done = 1; left only by reset
module banked_regfile
   import rf_pkg::*;
#(
   parameter  int NUM_BANKS = RF_NUM_BANKS,
   parameter  int DEPTH     = RF_DEPTH,
   parameter  int LANES     = RF_LANES,
   parameter  int DATA_W    = RF_DATA_W,
   parameter  int OCID_W    = RF_OCID_W,
   localparam int ADDR_W    = clog2_min1(DEPTH),
   localparam int EW        = LANES * DATA_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic                          init_done,
   input  logic [NUM_BANKS-1:0]          rd_req,
   input  logic [NUM_BANKS*ADDR_W-1:0]   rd_addr,
   input  logic [NUM_BANKS*OCID_W-1:0]   rd_ocid,
   input  logic [NUM_BANKS-1:0]          rd_same,
   input  logic [NUM_BANKS-1:0]          wr_en,
   input  logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_BANKS*LANES-1:0]    wr_mask,
   input  logic [NUM_BANKS*EW-1:0]       wr_data,
   output logic [NUM_BANKS-1:0]          rd_valid,
   output logic [NUM_BANKS*EW-1:0]       rd_data,
   output logic [NUM_BANKS*OCID_W-1:0]   rd_ocid_q,
   output logic [NUM_BANKS-1:0]          rd_same_q
);

   logic              state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   logic [NUM_BANKS-1:0]        bk_rd_req;
   logic [NUM_BANKS-1:0]        bk_wr_en;
   logic [NUM_BANKS*ADDR_W-1:0] bk_wr_addr;
   logic [NUM_BANKS*LANES-1:0]  bk_wr_mask;
   logic [NUM_BANKS*EW-1:0]     bk_wr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + ADDR_W'(1);
         if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
         end
      end
   end

   // During the sweep the banks see a full-mask zero write at entry cnt and
   // no reads; afterwards the external ports pass straight through.
   always_comb begin
      init_done  = (state_q == ST_RUN);
      bk_rd_req  = '0;
      bk_wr_en   = '1;
      bk_wr_addr = '0;
      bk_wr_mask = '1;
      bk_wr_data = '0;
      if (state_q == ST_INIT) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            bk_wr_addr[b*ADDR_W +: ADDR_W] = cnt_q;
         end
      end else begin
         bk_rd_req  = rd_req;
         bk_wr_en   = wr_en;
         bk_wr_addr = wr_addr;
         bk_wr_mask = wr_mask;
         bk_wr_data = wr_data;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      rf_bank #(
         .DEPTH  (DEPTH),
         .LANES  (LANES),
         .DATA_W (DATA_W),
         .OCID_W (OCID_W)
      ) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd_req    (bk_rd_req[b]),
         .rd_addr   (rd_addr[b*ADDR_W +: ADDR_W]),
         .rd_ocid   (rd_ocid[b*OCID_W +: OCID_W]),
         .rd_same   (rd_same[b]),
         .wr_en     (bk_wr_en[b]),
         .wr_addr   (bk_wr_addr[b*ADDR_W +: ADDR_W]),
         .wr_mask   (bk_wr_mask[b*LANES +: LANES]),
         .wr_data   (bk_wr_data[b*EW +: EW]),
         .rd_valid  (rd_valid[b]),
         .rd_data   (rd_data[b*EW +: EW]),
         .rd_ocid_q (rd_ocid_q[b*OCID_W +: OCID_W]),
         .rd_same_q (rd_same_q[b])
      );
   end

endmodule
